ram_input_loader: RTL and testbench

RAM_INPUT_LOADER -- requirements
Module: ram_input_loader

---
 rtl/snn_pkg.sv | 17 +
 rtl/ram_input_loader.sv | 126 ++++++++++++
 tb/tb_ram_input_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN input path: pixel loader and the input RAM it feeds.
package snn_pkg;

    localparam int unsigned NUM_BITS_DEFAULT   = 784;
    localparam int unsigned ADDR_WIDTH_DEFAULT = 10;
    localparam int unsigned RAM_DEPTH          = 1 << ADDR_WIDTH_DEFAULT;
    localparam int unsigned PIXEL_BYTE_W       = 8;
    localparam int unsigned BIT_CNT_W          = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        SHIFT     = 2'd2,
        FINISH    = 2'd3
    } load_state_t;

endpackage

// File: rtl/ram_input_loader.sv
// Unpacks a stream of pixel bytes (LSB first) into single-bit writes to the input RAM.
module ram_input_loader
    import snn_pkg::*;
#(
    parameter int unsigned NUM_BITS   = NUM_BITS_DEFAULT,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [PIXEL_BYTE_W-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    ram_data,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic                    ram_we,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NUM_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(PIXEL_BYTE_W - 1);

    load_state_t             state, state_next;
    logic [PIXEL_BYTE_W-1:0] shreg, shreg_next;
    logic [ADDR_WIDTH-1:0]   pix_cnt, pix_cnt_next;
    logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_next;
    logic                    ram_we_next;
    logic                    ram_data_next;
    logic [ADDR_WIDTH-1:0]   ram_addr_next;
    logic                    last_pix;
    logic                    last_bit;

    assign last_pix = (pix_cnt == LAST_PIX);
    assign last_bit = (bit_cnt == LAST_BIT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the final pixel wins over the end of a byte
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start)    state_next = WAIT_BYTE;
            WAIT_BYTE: if (in_valid) state_next = SHIFT;
            SHIFT: begin
                if (last_pix)      state_next = FINISH;
                else if (last_bit) state_next = WAIT_BYTE;
            end
            FINISH:    state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Datapath and output next values; RAM port is loaded one edge ahead so it is registered
    always_comb begin
        shreg_next    = shreg;
        pix_cnt_next  = pix_cnt;
        bit_cnt_next  = bit_cnt;
        ram_we_next   = 1'b0;
        ram_data_next = ram_data;
        ram_addr_next = ram_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    pix_cnt_next = '0;
                    bit_cnt_next = '0;
                end
            end
            WAIT_BYTE: begin
                if (in_valid) begin
                    shreg_next    = in_data;
                    bit_cnt_next  = '0;
                    ram_we_next   = 1'b1;
                    ram_data_next = in_data[0];
                    ram_addr_next = pix_cnt;
                end
            end
            SHIFT: begin
                shreg_next   = shreg >> 1;
                bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                if (!last_pix) begin
                    pix_cnt_next = pix_cnt + ADDR_WIDTH'(1);
                end
                if (state_next == SHIFT) begin
                    ram_we_next   = 1'b1;
                    ram_data_next = shreg[1];
                    ram_addr_next = pix_cnt + ADDR_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            pix_cnt  <= '0;
            bit_cnt  <= '0;
            ram_we   <= 1'b0;
            ram_data <= 1'b0;
            ram_addr <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            shreg    <= shreg_next;
            pix_cnt  <= pix_cnt_next;
            bit_cnt  <= bit_cnt_next;
            ram_we   <= ram_we_next;
            ram_data <= ram_data_next;
            ram_addr <= ram_addr_next;
            in_ready <= (state_next == WAIT_BYTE);
            busy     <= (state_next != IDLE);
            done     <= (state_next == FINISH);
        end
    end

endmodule

// File: tb/tb_ram_input_loader.sv
// Directed bench for ram_input_loader: cycle table plus full-load, random-valid, reset and short-sample sequences.
`timescale 1ns/1ps
module tb_ram_input_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, ram_data, ram_we, busy, done;
    logic [9:0] ram_addr;

    logic       s_rst, s_start, s_in_valid;
    logic [7:0] s_in_data;
    logic       s_in_ready, s_ram_data, s_ram_we, s_busy, s_done;
    logic [3:0] s_ram_addr;

    ram_input_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
        .busy(busy), .done(done)
    );

    ram_input_loader #(.NUM_BITS(12), .ADDR_WIDTH(4)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .ram_data(s_ram_data), .ram_addr(s_ram_addr), .ram_we(s_ram_we),
        .busy(s_busy), .done(s_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Write/done log per DUT, sampled on the falling edge
    logic [9:0] wr_addr [0:4095];
    logic       wr_bit  [0:4095];
    int         wr_n = 0;
    int         done_n = 0;
    logic [3:0] s_wr_addr [0:31];
    logic       s_wr_bit  [0:31];
    int         s_wr_n = 0;
    int         s_done_n = 0;

    always @(negedge clk) begin
        if (ram_we && wr_n < 4096) begin
            wr_addr[wr_n] <= ram_addr;
            wr_bit[wr_n]  <= ram_data;
            wr_n          <= wr_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    always @(negedge clk) begin
        if (s_ram_we && s_wr_n < 32) begin
            s_wr_addr[s_wr_n] <= s_ram_addr;
            s_wr_bit[s_wr_n]  <= s_ram_data;
            s_wr_n            <= s_wr_n + 1;
        end
        if (s_done) s_done_n <= s_done_n + 1;
    end

    typedef struct {
        logic       rst, start, valid;
        logic [7:0] data;
        logic       ready, we, bitv;
        logic [9:0] addr;
        logic       busy, done;
    } vec_t;

    vec_t vecs [0:23];

    task automatic setv(input int i, input int r, input int s, input int v, input int d,
                        input int rdy, input int w, input int b, input int a,
                        input int bz, input int dn);
        vecs[i].rst   = 1'(r);
        vecs[i].start = 1'(s);
        vecs[i].valid = 1'(v);
        vecs[i].data  = 8'(d);
        vecs[i].ready = 1'(rdy);
        vecs[i].we    = 1'(w);
        vecs[i].bitv  = 1'(b);
        vecs[i].addr  = 10'(a);
        vecs[i].busy  = 1'(bz);
        vecs[i].done  = 1'(dn);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [7:0] pat_a, pat_b, tmp;
    logic [7:0] rbytes [0:97];
    logic       got;
    int         base, dbase, errs, idx, sidx;
    logic       prev_we;
    logic [3:0] prev_addr;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        s_rst = 1'b1; s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00;

        // Cycle table: bytes 0xA5, 0x3C, then 0xFF, with start/valid noise during SHIFT and a mid-load reset
        pat_a = 8'hA5;
        pat_b = 8'h3C;
        setv(0,  0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0);
        setv(1,  0, 1, 0, 8'h00,  0, 0, 0, 0, 0, 0);
        setv(2,  0, 0, 1, 8'hA5,  1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) setv(3 + k, 0, 0, 0, 8'h00, 0, 1, int'(pat_a[k]), k, 1, 0);
        setv(11, 0, 0, 1, 8'h3C,  1, 0, 1, 7, 1, 0);
        for (int k = 0; k < 8; k++) setv(12 + k, 0, (k == 0) ? 1 : 0, 1, 8'hFF, 0, 1, int'(pat_b[k]), 8 + k, 1, 0);
        setv(20, 0, 0, 1, 8'hFF,  1, 0, 0, 15, 1, 0);
        setv(21, 0, 0, 0, 8'h00,  0, 1, 1, 16, 1, 0);
        setv(22, 1, 0, 0, 8'h00,  0, 1, 1, 17, 1, 0);
        setv(23, 0, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0);

        do_reset();
        #0 s_rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            rst = vecs[i].rst; start = vecs[i].start;
            in_valid = vecs[i].valid; in_data = vecs[i].data;
            @(negedge clk);
            chk($sformatf("vec%0d {rdy,we,bit,addr,busy,done}", i),
                {in_ready, ram_we, ram_data, ram_addr, busy, done},
                {vecs[i].ready, vecs[i].we, vecs[i].bitv, vecs[i].addr, vecs[i].busy, vecs[i].done});
        end

        // Full load of 0xFF with valid held high; start pulsed in SHIFT and in FINISH
        do_reset();
        @(negedge clk);
        base = wr_n; dbase = done_n;
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ram_we && ram_addr == 10'd100) start = 1'b1;
            if (done) begin start = 1'b1; got = 1'b1; end
        end
        chk("full_done_seen", longint'(got), 1);
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(negedge clk);
        chk("full_write_count", wr_n - base, 784);
        errs = 0;
        for (int k = 0; k < 784; k++)
            if (wr_addr[base + k] != 10'(k) || wr_bit[base + k] != 1'b1) errs++;
        chk("full_addr_data_seq", errs, 0);
        chk("full_last_addr", longint'(wr_addr[base + 783]), 783);
        chk("full_done_pulses", done_n - dbase, 1);
        chk("full_idle_after {busy,ready,we}", {busy, in_ready, ram_we}, 0);

        // Random valid pattern against a byte-level reference
        do_reset();
        @(negedge clk);
        base = wr_n;
        for (int i = 0; i < 98; i++) rbytes[i] = 8'($urandom);
        idx = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 4000 && !got; c++) begin
            in_valid = ($urandom_range(0, 1) == 1) && (idx < 98);
            in_data  = (idx < 98) ? rbytes[idx] : 8'h00;
            @(negedge clk);
            if (in_ready && in_valid) idx++;
            if (done) got = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("rand_done_seen", longint'(got), 1);
        repeat (3) @(negedge clk);
        chk("rand_bytes_consumed", idx, 98);
        chk("rand_write_count", wr_n - base, 784);
        errs = 0;
        for (int k = 0; k < 784; k++) begin
            tmp = rbytes[k / 8];
            if (wr_addr[base + k] != 10'(k) || wr_bit[base + k] != tmp[k % 8]) errs++;
        end
        chk("rand_vs_reference", errs, 0);

        // Reset at pixel 300, then a fresh load from address 0
        do_reset();
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk);
            if (ram_we && ram_addr == 10'd300) begin rst = 1'b1; got = 1'b1; end
        end
        chk("rst300_reached", longint'(got), 1);
        @(negedge clk);
        chk("rst300_outputs {rdy,we,bit,addr,busy,done}",
            {in_ready, ram_we, ram_data, ram_addr, busy, done}, 0);
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        base = wr_n;
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 20 && wr_n < base + 2; c++) @(negedge clk);
        chk("reload_writes_seen", longint'(wr_n >= base + 2), 1);
        chk("reload_first {addr,bit}", {wr_addr[base], wr_bit[base]}, {10'd0, 1'b0});
        chk("reload_second {addr,bit}", {wr_addr[base + 1], wr_bit[base + 1]}, {10'd1, 1'b1});
        do_reset();

        // NUM_BITS=12: second byte contributes only its low nibble
        pat_a = 8'hC3;
        pat_b = 8'h3A;
        @(negedge clk);
        base = s_wr_n; dbase = s_done_n;
        @(posedge clk); #1 s_start = 1'b1; s_in_valid = 1'b1; s_in_data = pat_a;
        @(posedge clk); #1 s_start = 1'b0;
        sidx = 0; got = 1'b0; prev_we = 1'b0; prev_addr = 4'd0;
        for (int c = 0; c < 100 && !got; c++) begin
            s_in_data = (sidx == 0) ? pat_a : pat_b;
            @(negedge clk);
            if (s_done) begin
                got = 1'b1;
                chk("small_done_after_addr11 {prev_we,prev_addr,we}",
                    {prev_we, prev_addr, s_ram_we}, {1'b1, 4'd11, 1'b0});
            end
            if (s_in_ready && s_in_valid) sidx++;
            prev_we = s_ram_we; prev_addr = s_ram_addr;
            @(posedge clk); #1;
        end
        chk("small_done_seen", longint'(got), 1);
        repeat (10) @(negedge clk);
        chk("small_write_count", s_wr_n - base, 12);
        errs = 0;
        for (int k = 0; k < 12; k++) begin
            tmp = (k < 8) ? pat_a : pat_b;
            if (s_wr_addr[base + k] != 4'(k) || s_wr_bit[base + k] != tmp[k % 8]) errs++;
        end
        chk("small_addr_data_seq", errs, 0);
        chk("small_bytes_consumed", sidx, 2);
        chk("small_done_pulses", s_done_n - dbase, 1);
        chk("small_idle_after {busy,ready}", {s_busy, s_in_ready}, 0);
        s_in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
